// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, framing constants and the
// oversampling divider calculation used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS   = 8;
    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 8;
    localparam int SYNC_STAGES = 2;

    function automatic int calc_div(input int clock_rate, input int baud_rate);
        return clock_rate / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling prescaler: one-cycle tick every DIV clocks, with a clear that
// re-anchors the phase so the first tick lands exactly DIV cycles later.
module uart_os_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_os_tick: DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             at_top;

    assign at_top = (cnt_reg == CNT_W'(DIV - 1));

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (clear || at_top) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // A clear cycle never produces a tick, even if the count happened to be at the top.
    assign tick = at_top && !clear;

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling: synchronizer, start-edge detect,
// mid-bit sampling FSM and a byte output with valid / framing-error strobes.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] primed_reg;
    logic                   prev_reg;
    logic                   sync;
    logic                   fall;

    uart_state_t state_reg, state_next;
    logic [3:0]  os_reg, os_next;
    logic [2:0]  bi_reg, bi_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  data_reg, data_next;
    logic        valid_reg, valid_next;
    logic        ferr_reg, ferr_next;
    logic        tick_clear;
    logic        tick;

    assign sync = sync_reg[SYNC_STAGES-1];
    assign fall = prev_reg && !sync;

    // prev only follows the line once the synchronizer holds real samples, so
    // the reset-to-1 synchronizer value can never fake a "line was high".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= '1;
            primed_reg <= '0;
            prev_reg   <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], rx};
            primed_reg <= {primed_reg[SYNC_STAGES-2:0], 1'b1};
            prev_reg   <= primed_reg[SYNC_STAGES-1] ? sync : 1'b0;
        end
    end

    uart_os_tick #(
        .DIV(DIV)
    ) u_os_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(tick_clear),
        .tick (tick)
    );

    always_comb begin
        state_next = state_reg;
        os_next    = os_reg;
        bi_next    = bi_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        tick_clear = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fall) begin
                    tick_clear = 1'b1;
                    os_next    = '0;
                    state_next = START;
                end
            end

            START: begin
                if (tick) begin
                    if (os_reg == 4'(MID_SAMPLE - 1)) begin
                        os_next = '0;
                        if (!sync) begin
                            bi_next    = '0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        os_next = os_reg + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (os_reg == 4'(OVERSAMPLE - 1)) begin
                        os_next    = '0;
                        shift_next = {sync, shift_reg[7:1]};
                        bi_next    = bi_reg + 3'd1;
                        if (bi_reg == 3'(DATA_BITS - 1)) begin
                            state_next = STOP;
                        end
                    end else begin
                        os_next = os_reg + 4'd1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (os_reg == 4'(OVERSAMPLE - 1)) begin
                        os_next    = '0;
                        state_next = IDLE;
                        if (sync) begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end else begin
                            ferr_next = 1'b1;
                        end
                    end else begin
                        os_next = os_reg + 4'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            os_reg    <= '0;
            bi_reg    <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            os_reg    <= os_next;
            bi_reg    <= bi_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = ferr_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed plus randomized frames for uart_rx_os16 at DIV=10 (160 clocks per bit),
// checked against a frame-level model of expected bytes, strobes and timing.
module tb_uart_rx_os16;

    localparam int CLOCK_RATE = 1600;
    localparam int BAUD_RATE  = 10;
    localparam int TB_DIV     = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int BIT        = 16 * TB_DIV;
    localparam int SYNC_LAT   = 2;
    localparam int LAT        = SYNC_LAT + 152 * TB_DIV + 1;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_os16 #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] val_q[$];
    int         vcyc_q[$];
    int         ferr_q[$];
    int         both_hi = 0;
    int         busy_rise = -1;
    int         busy_fall = -1;
    logic       busy_prev = 1'b0;
    logic [7:0] model_last = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                val_q.push_back(rx_data);
                vcyc_q.push_back(cyc);
            end
            if (frame_err) ferr_q.push_back(cyc);
            if (rx_valid && frame_err) both_hi++;
            if (busy && !busy_prev) busy_rise = cyc;
            if (!busy && busy_prev) busy_fall = cyc;
        end
        busy_prev = busy;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bl,
                              input int hold_low, output int drop);
        @(negedge clk);
        rx   = 1'b0;
        drop = cyc;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bl) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bl) @(negedge clk);
        if (hold_low > 0) begin
            rx = 1'b0;
            repeat (hold_low) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input bit good, input logic [7:0] b,
                                input int drop);
        int pulse_cyc;
        for (int w = 0; w < 400 && val_q.size() == 0 && ferr_q.size() == 0; w++)
            @(negedge clk);
        chk({tag, "_valid_n"}, val_q.size(), good ? 1 : 0);
        chk({tag, "_ferr_n"}, ferr_q.size(), good ? 0 : 1);
        pulse_cyc = -1;
        if (good && val_q.size() > 0) begin
            chk({tag, "_data"}, val_q[0], b);
            pulse_cyc = vcyc_q[0];
        end
        if (!good && ferr_q.size() > 0) pulse_cyc = ferr_q[0];
        if (good) model_last = b;
        chk({tag, "_latency"}, pulse_cyc - drop, LAT);
        chk({tag, "_busy_rise"}, busy_rise, drop + SYNC_LAT + 1);
        chk({tag, "_busy_fall"}, busy_fall, pulse_cyc);
        chk({tag, "_rx_data"}, rx_data, model_last);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_overlap"}, both_hi, 0);
        val_q.delete();
        vcyc_q.delete();
        ferr_q.delete();
    endtask

    initial begin
        int         drop;
        logic [7:0] seq3[3];
        logic [7:0] rb;
        bit         rgood;
        int         rbl;
        int         rgap;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);

        send_frame(8'h55, 1'b1, BIT, 0, drop);
        expect_frame("f55", 1'b1, 8'h55, drop);
        repeat (BIT) @(negedge clk);

        seq3[0] = 8'h00;
        seq3[1] = 8'hFF;
        seq3[2] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            send_frame(seq3[k], 1'b1, BIT, 0, drop);
            expect_frame($sformatf("b2b%0d", k), 1'b1, seq3[k], drop);
            repeat (BIT - 1) @(negedge clk);
        end

        send_frame(8'h3C, 1'b0, BIT, 5 * BIT, drop);
        expect_frame("f3c_ferr", 1'b0, 8'h3C, drop);
        repeat (BIT) @(negedge clk);
        send_frame(8'h81, 1'b1, BIT, 0, drop);
        expect_frame("f81", 1'b1, 8'h81, drop);
        repeat (BIT) @(negedge clk);

        // Short low glitch: rejected at the mid-start sample.
        @(negedge clk);
        rx   = 1'b0;
        drop = cyc;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (52) @(negedge clk);
        chk("glitch_busy_before_sample", busy, 1'b1);
        @(negedge clk);
        chk("glitch_busy_after_sample", busy, 1'b0);
        repeat (200) @(negedge clk);
        chk("glitch_valid_n", val_q.size(), 0);
        chk("glitch_ferr_n", ferr_q.size(), 0);
        chk("glitch_rx_data", rx_data, model_last);

        // Reset in the middle of data bit 4 (a low bit) of 0x0F.
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_last = 8'h00;
        chk("midrst_rx_data", rx_data, model_last);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        busy_rise = -1;
        repeat (3 * BIT) @(negedge clk);
        chk("postrst_low_busy_rise", busy_rise, -1);
        chk("postrst_low_valid_n", val_q.size(), 0);
        chk("postrst_low_ferr_n", ferr_q.size(), 0);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        send_frame(8'h7E, 1'b1, BIT, 0, drop);
        expect_frame("f7e_after_rst", 1'b1, 8'h7E, drop);
        repeat (BIT) @(negedge clk);

        send_frame(8'h5A, 1'b1, 155, 0, drop);
        expect_frame("f5a_skew", 1'b1, 8'h5A, drop);
        repeat (BIT) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            rb    = 8'($urandom_range(0, 255));
            rgood = ($urandom_range(0, 3) != 0);
            rbl   = $urandom_range(157, 163);
            rgap  = $urandom_range(20, 200);
            send_frame(rb, rgood, rbl, 0, drop);
            expect_frame($sformatf("rnd%0d_%02h", k, rb), rgood, rb, drop);
            repeat (rgap) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
